// File: rtl/gate_chk_pkg.sv
// Shared definitions for the gate response checker: FSM state encoding,
// settle-counter width and the stock two-input truth tables.
// Truth tables are indexed by {a,b}, so bit 3 is the a=1,b=1 response.
package gate_chk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETTLE   = 3'd1,
    ST_CHECK    = 3'd2,
    ST_WAIT_CHG = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  // Settle counter holds SETTLE_CYCLES-1 down to 0 (SETTLE_CYCLES is 1..255)
  localparam int SETTLE_W = 8;

  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; used for the vector and
// mismatch counts of the gate response checker.
module sat_counter
  import gate_chk_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear has priority, increment stops at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/gate_response_checker.sv
// Gate response checker: watches the stimulus pair {a,b} and the gate output,
// waits for each new vector to settle, compares the output against
// TRUTH_TABLE and reports vector/mismatch counts plus pass/fail at run end.
// Optional build macro GATE_CHK_FIRST_ERR_EN adds first_err_o = {valid,a,b}
// holding the first mismatching vector of the run.
module gate_response_checker
  import gate_chk_pkg::*;
#(
  parameter logic [3:0] TRUTH_TABLE   = TT_AND,
  parameter int         SETTLE_CYCLES = 4,
  parameter int         NUM_VECTORS   = 4,
  parameter int         CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             a_i,
  input  logic             b_i,
  input  logic             out_i,
  output logic             busy_o,
  output logic             err_pulse_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [3:0]       cover_o,
`ifdef GATE_CHK_FIRST_ERR_EN
  output logic [2:0]       first_err_o,
`endif
  output logic [CNT_W-1:0] vec_count_o,
  output logic [CNT_W-1:0] err_count_o
);

  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W:0]      NUM_VEC_L   = (CNT_W+1)'(NUM_VECTORS);

  state_e              state_q;
  logic [1:0]          last_q;
  logic [SETTLE_W-1:0] settle_q;
  logic [3:0]          cover_q;
  logic                busy_q;
  logic                err_pulse_q;
  logic                done_q;
  logic                pass_q;

  logic [1:0]          vec;
  logic                vec_changed;
  logic                start_ok;
  logic                in_check;
  logic                mismatch;
  logic [3:0]          cover_d;
  logic [CNT_W:0]      vec_count_d;
  logic                last_vec;

  assign vec         = {a_i, b_i};
  assign vec_changed = (vec != last_q);
  // start is only honoured between runs; while a run is active it is dropped
  assign start_ok    = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign in_check    = (state_q == ST_CHECK);
  assign mismatch    = in_check && (out_i != TRUTH_TABLE[last_q]);
  assign cover_d     = cover_q | (4'b0001 << last_q);
  // Widened by one bit so the compare cannot wrap when NUM_VECTORS is at max
  assign vec_count_d = {1'b0, vec_count_o} + (CNT_W+1)'(1);
  assign last_vec    = (vec_count_d == NUM_VEC_L);

  sat_counter #(.W(CNT_W)) u_vec_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (start_ok),
    .inc_i (in_check),
    .cnt_o (vec_count_o)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (start_ok),
    .inc_i (mismatch),
    .cnt_o (err_count_o)
  );

  // Run sequencing FSM with registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      last_q      <= 2'b00;
      settle_q    <= '0;
      cover_q     <= 4'h0;
      busy_q      <= 1'b0;
      err_pulse_q <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      err_pulse_q <= mismatch;
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            cover_q  <= 4'h0;
            last_q   <= vec;
            settle_q <= SETTLE_LOAD;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            state_q  <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (vec_changed) begin
            // Input glitched: restart the settle window on the new value
            last_q   <= vec;
            settle_q <= SETTLE_LOAD;
          end else if (settle_q == '0) begin
            state_q  <= ST_CHECK;
          end else begin
            settle_q <= settle_q - SETTLE_W'(1);
          end
        end
        ST_CHECK: begin
          cover_q <= cover_d;
          if (last_vec) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_count_o == '0) && !mismatch && (cover_d == 4'hF);
            state_q <= ST_DONE;
          end else begin
            state_q <= ST_WAIT_CHG;
          end
        end
        ST_WAIT_CHG: begin
          if (vec_changed) begin
            last_q   <= vec;
            settle_q <= SETTLE_LOAD;
            state_q  <= ST_SETTLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef GATE_CHK_FIRST_ERR_EN
  logic [2:0] first_err_q;

  // Capture the first mismatching vector of a run; later mismatches leave it alone
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_err_q <= 3'b000;
    end else if (start_ok) begin
      first_err_q <= 3'b000;
    end else if (mismatch && !first_err_q[2]) begin
      first_err_q <= {1'b1, last_q};
    end
  end

  assign first_err_o = first_err_q;
`endif

  assign busy_o      = busy_q;
  assign err_pulse_o = err_pulse_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign cover_o     = cover_q;

endmodule

// File: tb/tb_gate_response_checker.sv
// Self-checking bench for gate_response_checker (default AND table,
// SETTLE_CYCLES=4, NUM_VECTORS=4). Expected checks are queued as vectors are
// driven and popped when the DUT's vector count advances.
module tb_gate_response_checker;

  typedef struct packed {
    logic [1:0] vec;
    logic       mis;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       start_i;
  logic       a_i;
  logic       b_i;
  logic       out_i;
  logic       busy_o;
  logic       err_pulse_o;
  logic       done_o;
  logic       pass_o;
  logic [3:0] cover_o;
  logic [7:0] vec_count_o;
  logic [7:0] err_count_o;
`ifdef GATE_CHK_FIRST_ERR_EN
  logic [2:0] first_err_o;
`endif

  int         checks;
  int         failures;
  exp_t       sb[$];
  logic [7:0] prev_vc;
  logic [3:0] ref_tt;
  logic       force_en;
  logic [1:0] force_vec;

  gate_response_checker dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .out_i       (out_i),
    .busy_o      (busy_o),
    .err_pulse_o (err_pulse_o),
    .done_o      (done_o),
    .pass_o      (pass_o),
    .cover_o     (cover_o),
`ifdef GATE_CHK_FIRST_ERR_EN
    .first_err_o (first_err_o),
`endif
    .vec_count_o (vec_count_o),
    .err_count_o (err_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic gate_model(input logic [1:0] v);
    if (force_en && (v == force_vec)) return 1'b1;
    return v[1] & v[0];
  endfunction

  // Gate under test, optionally with a stuck-high fault on one vector
  always_comb out_i = gate_model({a_i, b_i});

  task automatic push_exp(input logic [1:0] v);
    exp_t e;
    e.vec = v;
    e.mis = (ref_tt[v] != gate_model(v));
    sb.push_back(e);
  endtask

  // Scoreboard: every vec_count advance must match the oldest queued check
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (vec_count_o > prev_vc)) begin
      checks++;
      if (vec_count_o !== prev_vc + 8'd1) begin
        failures++;
        $display("FAIL vc_step got=%0d want=%0d", vec_count_o, prev_vc + 8'd1);
      end
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb_unexpected_check vc=%0d", vec_count_o);
      end else begin
        e = sb.pop_front();
        checks++;
        if (err_pulse_o !== e.mis) begin
          failures++;
          $display("FAIL sb_err_pulse vec=%b got=%b want=%b", e.vec, err_pulse_o, e.mis);
        end
        checks++;
        if (cover_o[e.vec] !== 1'b1) begin
          failures++;
          $display("FAIL sb_cover vec=%b got=%b", e.vec, cover_o);
        end
      end
    end else if (!rst && (err_pulse_o === 1'b1)) begin
      checks++; failures++;
      $display("FAIL sb_spurious_err_pulse vc=%0d", vec_count_o);
    end
    prev_vc = vec_count_o;
  end

  task automatic pulse_start();
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic start_run(input logic [1:0] v, input int hold);
    a_i = v[1]; b_i = v[0];
    push_exp(v);
    pulse_start();
    repeat (hold - 1) @(posedge clk);
    #1;
  endtask

  task automatic drive_vec(input logic [1:0] v, input int hold, input bit expect_check);
    a_i = v[1]; b_i = v[0];
    if (expect_check) push_exp(v);
    repeat (hold) @(posedge clk);
    #1;
  endtask

  task automatic run_four_and_check(input string tag);
    start_run(2'b00, 10);
    drive_vec(2'b10, 10, 1'b1);
    drive_vec(2'b01, 10, 1'b1);
    drive_vec(2'b11, 10, 1'b1);
    @(negedge clk);
    checks++; if (vec_count_o !== 8'd4) begin failures++; $display("FAIL %s_vc got=%0d want=4", tag, vec_count_o); end
    checks++; if (err_count_o !== 8'd0) begin failures++; $display("FAIL %s_ec got=%0d want=0", tag, err_count_o); end
    checks++; if (cover_o !== 4'hF) begin failures++; $display("FAIL %s_cover got=%h want=F", tag, cover_o); end
    checks++; if (done_o !== 1'b1) begin failures++; $display("FAIL %s_done got=%b want=1", tag, done_o); end
    checks++; if (pass_o !== 1'b1) begin failures++; $display("FAIL %s_pass got=%b want=1", tag, pass_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL %s_busy got=%b want=0", tag, busy_o); end
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({busy_o, err_pulse_o, done_o, pass_o, cover_o, vec_count_o, err_count_o} !== 24'h0) begin
      failures++;
      $display("FAIL %s busy=%b errp=%b done=%b pass=%b cover=%h vc=%0d ec=%0d want all 0",
               tag, busy_o, err_pulse_o, done_o, pass_o, cover_o, vec_count_o, err_count_o);
    end
`ifdef GATE_CHK_FIRST_ERR_EN
    checks++;
    if (first_err_o !== 3'b000) begin
      failures++; $display("FAIL %s_first_err got=%b want=000", tag, first_err_o);
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b1; a_i = 1'b0; b_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    rst = 1'b0; start_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_wins_over_start busy got=%b want=0", busy_o); end
  endtask

  task automatic test_and_pass();
    run_four_and_check("and_pass");
  endtask

  task automatic test_mismatch();
    int pulse_at;
    int npulse;
    force_en = 1'b1; force_vec = 2'b10;
    start_run(2'b00, 10);
    a_i = 1'b1; b_i = 1'b0;
    push_exp(2'b10);
    pulse_at = -1; npulse = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (err_pulse_o === 1'b1) begin
        npulse++;
        pulse_at = n;
      end
    end
    checks++; if (pulse_at != 6) begin failures++; $display("FAIL mis_pulse_timing got=%0d want=6", pulse_at); end
    checks++; if (npulse != 1) begin failures++; $display("FAIL mis_pulse_count got=%0d want=1", npulse); end
    @(posedge clk); #1;
    drive_vec(2'b01, 10, 1'b1);
    drive_vec(2'b11, 10, 1'b1);
    @(negedge clk);
    checks++; if (err_count_o !== 8'd1) begin failures++; $display("FAIL mis_ec got=%0d want=1", err_count_o); end
    checks++; if (done_o !== 1'b1) begin failures++; $display("FAIL mis_done got=%b want=1", done_o); end
    checks++; if (pass_o !== 1'b0) begin failures++; $display("FAIL mis_pass got=%b want=0", pass_o); end
`ifdef GATE_CHK_FIRST_ERR_EN
    checks++; if (first_err_o !== 3'b110) begin failures++; $display("FAIL mis_first_err got=%b want=110", first_err_o); end
`endif
    force_en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_glitch_and_repeat();
    a_i = 1'b0; b_i = 1'b0;
    push_exp(2'b00);
    pulse_start();
    a_i = 1'b1;
    @(posedge clk); #1;
    a_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    @(negedge clk);
    checks++; if (vec_count_o !== 8'd0) begin failures++; $display("FAIL glitch_early_vc got=%0d want=0", vec_count_o); end
    @(negedge clk);
    checks++; if (vec_count_o !== 8'd1) begin failures++; $display("FAIL glitch_vc got=%0d want=1", vec_count_o); end
    checks++; if (cover_o !== 4'b0001) begin failures++; $display("FAIL glitch_cover got=%b want=0001", cover_o); end
    // Same vector held well past its check must not be counted again
    repeat (50) @(posedge clk);
    #1;
    checks++; if (vec_count_o !== 8'd1) begin failures++; $display("FAIL repeat_vc got=%0d want=1", vec_count_o); end
    checks++; if ((busy_o !== 1'b1) || (done_o !== 1'b0)) begin
      failures++; $display("FAIL repeat_state busy=%b done=%b want busy=1 done=0", busy_o, done_o);
    end
    pulse_start();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (vec_count_o !== 8'd1) begin failures++; $display("FAIL start_while_busy_vc got=%0d want=1", vec_count_o); end
  endtask

  task automatic test_reset_mid_run();
    drive_vec(2'b01, 10, 1'b1);
    drive_vec(2'b11, 2, 1'b1);
    checks++; if (vec_count_o !== 8'd2) begin failures++; $display("FAIL midrun_pre_vc got=%0d want=2", vec_count_o); end
    #2 rst = 1'b1;
    #1;
    check_all_zero("midrun_async_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    run_four_and_check("rerun");
  endtask

  task automatic test_cover_gap();
    start_run(2'b00, 10);
    drive_vec(2'b00, 10, 1'b0);
    drive_vec(2'b01, 10, 1'b1);
    drive_vec(2'b11, 10, 1'b1);
    drive_vec(2'b01, 10, 1'b1);
    @(negedge clk);
    checks++; if (done_o !== 1'b1) begin failures++; $display("FAIL gap_done got=%b want=1", done_o); end
    checks++; if (cover_o !== 4'b1011) begin failures++; $display("FAIL gap_cover got=%b want=1011", cover_o); end
    checks++; if (err_count_o !== 8'd0) begin failures++; $display("FAIL gap_ec got=%0d want=0", err_count_o); end
    checks++; if (pass_o !== 1'b0) begin failures++; $display("FAIL gap_pass got=%b want=0", pass_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    a_i = 1'b1; b_i = 1'b1;
    push_exp(2'b11);
    pulse_start();
    @(negedge clk);
    checks++; if ({done_o, pass_o, busy_o} !== 3'b001) begin
      failures++; $display("FAIL b2b_status done=%b pass=%b busy=%b want 0 0 1", done_o, pass_o, busy_o);
    end
    checks++; if ((vec_count_o !== 8'd0) || (cover_o !== 4'h0)) begin
      failures++; $display("FAIL b2b_clear vc=%0d cover=%h want 0 0", vec_count_o, cover_o);
    end
    repeat (8) @(posedge clk);
    #1;
    checks++; if (vec_count_o !== 8'd1) begin failures++; $display("FAIL b2b_vc got=%0d want=1", vec_count_o); end
    @(negedge clk);
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL sb_leftover got=%0d want=0", sb.size()); end
  endtask

  initial begin
    checks = 0; failures = 0;
    prev_vc = 8'd0;
    ref_tt = 4'b1000;
    force_en = 1'b0; force_vec = 2'b00;
    rst = 1'b1; start_i = 1'b0; a_i = 1'b0; b_i = 1'b0;
    test_reset();
    test_and_pass();
    test_mismatch();
    test_glitch_and_repeat();
    test_reset_mid_run();
    test_cover_gap();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
